traffic_signal_monitor: RTL and testbench
=========================================

// Module: traffic_signal_monitor
// PURPOSE
// Passive checker on the far end of the trafficController output interface. It samples T1/T2, T1Walk/T2Walk and
// Buzzer every clk and flags unsafe or out-of-spec signal sequences: conflicts, illegal transitions, short phases,
// red starvation and walk violations. It sits beside the controller in the top-level and drives no controller inputs.
// PARAMETERS
// MIN_GREEN   10   min green dwell in clk cycles (1 cycle = 1 s); not enforced while Buzzer=1
// MIN_YELLOW  3    min yellow dwell in clk cycles; always enforced
// MAX_RED     60   max red dwell before starvation flag; not enforced while Buzzer=1
// CNT_W       8    width of dwell counters and err_count
// PORTS
// clk         in   1      system clock; all logic on posedge
// reset       in   1      synchronous, active-high
// T1          in   3      approach-1 lamps, one-hot {red,yellow,green}: 100=R, 010=Y, 001=G
// T2          in   3      approach-2 lamps, same encoding
// T1Walk      in   1      pedestrian walk for crossing gated by approach 1
// T2Walk      in   1      pedestrian walk for crossing gated by approach 2
// Buzzer      in   1      controller emergency-mode indicator
// viol        out  1      one-cycle pulse: violation in the previous sample
// viol_code   out  3      code of that violation (valid when viol=1, else 0)
// fault       out  1      sticky: any violation since reset
// first_code  out  3      code of the first violation since reset (held)
// err_count   out  CNT_W  count of violating samples, saturates at all-ones
// BEHAVIOUR
// - Reset (sync, high): viol=0, viol_code=0, fault=0, first_code=0, err_count=0; both trackers -> INIT, dwell=0.
//   Reset asserted mid-operation clears everything at that edge; reset beats any violation in the same cycle.
// - Per-approach tracker FSM: INIT, RED, YEL, GRN. The sample on edge k updates state; outputs are registered and
//   reflect edge-k checks during cycle k+1 (latency 1).
// - INIT: first valid one-hot sample is adopted, no transition check, dwell=1. Non-one-hot in INIT stays INIT.
// - Dwell: consecutive samples in the current state, including current; on a state change it reloads to 1.
//   Saturating at all-ones. Transition checks use the dwell held before reload.
// - Legal transitions: R->G, G->Y, Y->R, or no change. Everything else is code 3.
// - Codes (priority low number wins when several fire in one sample):
//   1 illegal encoding: T1 or T2 not one-hot (incl. 000). The tracker holds its state and dwell does not advance.
//   2 conflict: neither T1 nor T2 red (both in {G,Y}) at the same sample.
//   3 illegal transition (G->R, R->Y, Y->G).
//   4 short green: G->Y with prior dwell < MIN_GREEN and Buzzer=0 at that sample.
//   5 short yellow: Y->R with prior dwell < MIN_YELLOW.
//   6 red starvation: red dwell == MAX_RED exactly and Buzzer=0. Fires once per red interval. If Buzzer is high at
//     that sample, no later flag fires in the same interval.
//   7 walk violation: TxWalk=1 while Tx is not red.
// - Each sample with >=1 violation: viol=1, viol_code=winning code, err_count+1 (once, not per code).
//   On the first such sample, fault=1 and first_code=code. Samples after that leave first_code unchanged.
// - Checks for both approaches are evaluated in parallel. A code from either approach counts. There is no
//   per-approach attribution.
// - Codes 2 and 7 are also checked while a tracker is in INIT, using raw one-hot inputs.
// TESTING
// 1 reset; T1=001,T2=100 for 12 cyc; T1=010 for 3; T1=100,T2=001 -> viol never 1, err_count=0, fault=0
// 2 T1=001,T2=001 for 1 sample -> next cycle viol=1,viol_code=2; fault=1,first_code=2; err_count=1
// 3 T1 green 5 cyc then 010 with Buzzer=0 -> viol_code=4; repeat with Buzzer=1 -> no viol
// 4 T1 Y for 2 cyc then 100 -> code 5; separately T1 001->100 -> code 3, first_code keeps earlier value
// 5 T2=100 held 70 cyc, Buzzer=0 -> exactly one viol, code 6, on sample 60; Buzzer=1 same run -> none
// 6 T1=011 with T1Walk=1 -> code 1 (priority over 7), err_count+1; force 300 violating samples -> err_count=255;
//   assert reset mid-fault -> all outputs 0 next cycle

Source files
------------

// File: rtl/traffic_signal_monitor.sv
// Passive safety monitor for a two-approach traffic controller: tracks each approach's lamp
// phase and flags encoding, conflict, transition, dwell and walk violations with 1-cycle latency.

module tsm_tracker #(
   parameter int MIN_GREEN  = 10,
   parameter int MIN_YELLOW = 3,
   parameter int MAX_RED    = 60,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] i_lamp,
   input  logic       i_buzzer,
   output logic       o_enc_err,
   output logic       o_trans_err,
   output logic       o_short_g,
   output logic       o_short_y,
   output logic       o_starve
);
   typedef enum logic [1:0] {ST_INIT, ST_RED, ST_YEL, ST_GRN} st_t;

   localparam logic [2:0]       L_R   = 3'b100;
   localparam logic [2:0]       L_Y   = 3'b010;
   localparam logic [2:0]       L_G   = 3'b001;
   localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MIN_Y = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_RED);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   st_t              r_st, w_st_nxt, w_samp;
   logic [CNT_W-1:0] r_dwell, w_dwell_nxt, w_dwell_inc;
   logic             w_onehot;

   always_comb begin
      w_onehot    = (i_lamp == L_R) || (i_lamp == L_Y) || (i_lamp == L_G);
      w_samp      = (i_lamp == L_R) ? ST_RED : (i_lamp == L_Y) ? ST_YEL : ST_GRN;
      w_dwell_inc = (r_dwell == '1) ? r_dwell : r_dwell + ONE;
      w_st_nxt    = r_st;
      w_dwell_nxt = r_dwell;
      o_enc_err   = 1'b0;
      o_trans_err = 1'b0;
      o_short_g   = 1'b0;
      o_short_y   = 1'b0;
      if (!w_onehot) begin
         // bad encoding freezes the tracker so the interval resumes cleanly
         o_enc_err = 1'b1;
      end else if (r_st == ST_INIT) begin
         w_st_nxt    = w_samp;
         w_dwell_nxt = ONE;
      end else if (w_samp == r_st) begin
         w_dwell_nxt = w_dwell_inc;
      end else begin
         w_st_nxt    = w_samp;
         w_dwell_nxt = ONE;
         case (r_st)
            ST_RED:  o_trans_err = (w_samp != ST_GRN);
            ST_GRN: begin
               o_trans_err = (w_samp != ST_YEL);
               o_short_g   = (w_samp == ST_YEL) && (r_dwell < MIN_G) && !i_buzzer;
            end
            ST_YEL: begin
               o_trans_err = (w_samp != ST_RED);
               o_short_y   = (w_samp == ST_RED) && (r_dwell < MIN_Y);
            end
            default: o_trans_err = 1'b0;
         endcase
      end
      // only the sample that lands on MAX_RED fires, so saturation cannot repeat it
      o_starve = w_onehot && (w_st_nxt == ST_RED) && (w_dwell_nxt == MAX_R) && !i_buzzer &&
                 ((r_st != ST_RED) || (r_dwell != MAX_R));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_st    <= ST_INIT;
         r_dwell <= '0;
      end else begin
         r_st    <= w_st_nxt;
         r_dwell <= w_dwell_nxt;
      end
   end
endmodule

module traffic_signal_monitor #(
   parameter int MIN_GREEN  = 10,
   parameter int MIN_YELLOW = 3,
   parameter int MAX_RED    = 60,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       T1,
   input  logic [2:0]       T2,
   input  logic             T1Walk,
   input  logic             T2Walk,
   input  logic             Buzzer,
   output logic             viol,
   output logic [2:0]       viol_code,
   output logic             fault,
   output logic [2:0]       first_code,
   output logic [CNT_W-1:0] err_count
);
   logic [1:0][2:0]  w_lamp;
   logic [1:0]       w_enc, w_trans, w_sg, w_sy, w_starve;
   logic             w_conflict, w_walk, w_any;
   logic [2:0]       w_code;
   logic             r_viol, r_fault;
   logic [2:0]       r_code, r_first;
   logic [CNT_W-1:0] r_err;

   assign w_lamp = {T2, T1};

   for (genvar g = 0; g < 2; g++) begin : g_trk
      tsm_tracker #(
         .MIN_GREEN (MIN_GREEN),
         .MIN_YELLOW(MIN_YELLOW),
         .MAX_RED   (MAX_RED),
         .CNT_W     (CNT_W)
      ) u_trk (
         .clk        (clk),
         .reset      (reset),
         .i_lamp     (w_lamp[g]),
         .i_buzzer   (Buzzer),
         .o_enc_err  (w_enc[g]),
         .o_trans_err(w_trans[g]),
         .o_short_g  (w_sg[g]),
         .o_short_y  (w_sy[g]),
         .o_starve   (w_starve[g])
      );
   end

   // conflict and walk use raw lamps so they also cover trackers still in INIT
   always_comb begin
      w_conflict = ((T1 == 3'b001) || (T1 == 3'b010)) && ((T2 == 3'b001) || (T2 == 3'b010));
      w_walk     = (T1Walk && (T1 != 3'b100)) || (T2Walk && (T2 != 3'b100));
      if      (|w_enc)    w_code = 3'd1;
      else if (w_conflict) w_code = 3'd2;
      else if (|w_trans)  w_code = 3'd3;
      else if (|w_sg)     w_code = 3'd4;
      else if (|w_sy)     w_code = 3'd5;
      else if (|w_starve) w_code = 3'd6;
      else if (w_walk)    w_code = 3'd7;
      else                w_code = 3'd0;
      w_any = (w_code != 3'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_viol  <= 1'b0;
         r_code  <= '0;
         r_fault <= 1'b0;
         r_first <= '0;
         r_err   <= '0;
      end else begin
         r_viol <= w_any;
         r_code <= w_code;
         if (w_any) begin
            if (r_err != '1) r_err <= r_err + CNT_W'(1);
            if (!r_fault) begin
               r_fault <= 1'b1;
               r_first <= w_code;
            end
         end
      end
   end

   assign viol       = r_viol;
   assign viol_code  = r_code;
   assign fault      = r_fault;
   assign first_code = r_first;
   assign err_count  = r_err;
endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed bench for traffic_signal_monitor: hand-computed expectations for clean cycling,
// each violation code, priority, starvation timing, counter saturation and reset.

module tb_traffic_signal_monitor;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] T1, T2;
   logic       T1Walk, T2Walk, Buzzer;
   logic       viol, fault;
   logic [2:0] viol_code, first_code;
   logic [7:0] err_count;
   int         checks = 0;
   int         errors = 0;

   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

   traffic_signal_monitor dut (
      .clk       (clk),
      .reset     (reset),
      .T1        (T1),
      .T2        (T2),
      .T1Walk    (T1Walk),
      .T2Walk    (T2Walk),
      .Buzzer    (Buzzer),
      .viol      (viol),
      .viol_code (viol_code),
      .fault     (fault),
      .first_code(first_code),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // inputs set before the call are sampled at the next edge; outputs read 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int v, input int c, input int f,
                          input int fc, input int e);
      chk({tag, ".viol"}, int'(viol), v);
      chk({tag, ".code"}, int'(viol_code), c);
      chk({tag, ".fault"}, int'(fault), f);
      chk({tag, ".first"}, int'(first_code), fc);
      chk({tag, ".err"}, int'(err_count), e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      T1 = 3'b000; T2 = 3'b000; T1Walk = 0; T2Walk = 0; Buzzer = 0;
      reset = 1'b1;
      tick(); tick();
      chk_all("reset", 0, 0, 0, 0, 0);
      reset = 1'b0;

      // clean cycle: T1 G12 -> Y3 -> R while T2 R -> G
      T1 = G; T2 = R;
      for (int i = 0; i < 12; i++) begin tick(); chk("clean_g.viol", int'(viol), 0); end
      T1 = Y;
      for (int i = 0; i < 3; i++) begin tick(); chk("clean_y.viol", int'(viol), 0); end
      T1 = R; T2 = G;
      tick();
      chk_all("clean_swap", 0, 0, 0, 0, 0);

      // conflict: both green
      T1 = G;
      tick();
      chk_all("conflict", 1, 2, 1, 2, 1);

      // short green with Buzzer low, then tolerated with Buzzer high
      do_reset();
      T1 = G; T2 = R;
      for (int i = 0; i < 5; i++) begin tick(); chk("sg_pre.viol", int'(viol), 0); end
      chk("sg_pre.fault", int'(fault), 0);
      T1 = Y;
      tick();
      chk_all("short_green", 1, 4, 1, 4, 1);
      tick(); tick();
      chk("y_hold.viol", int'(viol), 0);
      T1 = R; T2 = G;
      tick();
      chk("y_to_r_ok.viol", int'(viol), 0);
      for (int i = 0; i < 4; i++) tick();
      T2 = Y; Buzzer = 1;
      tick();
      chk_all("sg_buzzer", 0, 0, 1, 4, 1);
      Buzzer = 0;

      // short yellow on T2 (dwell 2), first_code stays 4
      tick();
      T2 = R;
      tick();
      chk_all("short_yellow", 1, 5, 1, 4, 2);

      // illegal G->R on T1
      T1 = G;
      tick();
      chk("r_to_g.viol", int'(viol), 0);
      T1 = R;
      tick();
      chk_all("g_to_r", 1, 3, 1, 4, 3);

      // red starvation fires exactly on sample 60
      do_reset();
      T1 = G; T2 = R;
      for (int i = 1; i <= 70; i++) begin
         tick();
         chk("starve.viol", int'(viol), (i == 60) ? 1 : 0);
         if (i == 60) chk("starve.code", int'(viol_code), 6);
      end
      chk("starve.err", int'(err_count), 1);

      // Buzzer high only at sample 60 suppresses the whole interval
      do_reset();
      for (int i = 1; i <= 70; i++) begin
         Buzzer = (i == 60);
         tick();
         chk("starve_bz.viol", int'(viol), 0);
      end
      Buzzer = 0;
      chk("starve_bz.fault", int'(fault), 0);

      // encoding error beats walk violation, then saturate the counter
      do_reset();
      T1 = R; T2 = G;
      tick();
      chk("enc_pre.viol", int'(viol), 0);
      T1 = 3'b011; T1Walk = 1;
      tick();
      chk_all("enc_walk", 1, 1, 1, 1, 1);
      tick();
      chk("enc_err2", int'(err_count), 2);
      for (int i = 0; i < 300; i++) tick();
      chk_all("saturate", 1, 1, 1, 1, 255);

      // reset mid-fault beats the ongoing violation
      reset = 1'b1;
      tick();
      chk_all("reset_mid", 0, 0, 0, 0, 0);
      reset = 1'b0;
      T1 = R; T1Walk = 1;
      tick();
      chk("walk_red_ok.viol", int'(viol), 0);
      T2Walk = 1;
      tick();
      chk_all("walk_viol", 1, 7, 1, 7, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
